// File: rtl/theme_sequencer_if.sv
// theme_sequencer_if: button/frame inputs and committed theme outputs of the theme sequencer
interface theme_sequencer_if;
  logic       btn_next_n;
  logic       btn_prev_n;
  logic       auto_en;
  logic       frame_start;
  logic [2:0] theme;
  logic       theme_pending;
  logic       theme_changed;
  modport master (
    output btn_next_n, btn_prev_n, auto_en, frame_start,
    input  theme, theme_pending, theme_changed
  );
  modport slave (
    input  btn_next_n, btn_prev_n, auto_en, frame_start,
    output theme, theme_pending, theme_changed
  );
endinterface

// File: rtl/theme_sequencer.sv
// theme_sequencer: debounced next/prev/auto theme select, committed only on frame_start
module theme_sequencer #(
  parameter int         DEBOUNCE_CYCLES = 500000,
  parameter int         AUTO_FRAMES     = 180,
  parameter logic [2:0] RESET_THEME     = 3'd0
) (
  input logic clk,
  input logic rst_n,
  theme_sequencer_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int FW = $clog2(AUTO_FRAMES + 1);
  typedef enum logic {IDLE, PENDING} state_t;
  state_t state, state_n;
  logic [1:0] s1, s2, db, db_d1, ev;
  logic [CW-1:0] cnt [2];
  logic [FW-1:0] fcnt, fcnt_n;
  logic [2:0] theme, theme_n, target, target_n, tgt_ev;
  logic nx, pv, evt, auto_hit;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= '1;
      s2    <= '1;
      db    <= '1;
      db_d1 <= '1;
      cnt   <= '{default: '0};
    end else begin
      s1    <= {bus.btn_prev_n, bus.btn_next_n};
      s2    <= s1;
      db_d1 <= db;
      for (int i = 0; i < 2; i++)
        if (s2[i] == db[i]) cnt[i] <= '0;
        else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          db[i]  <= s2[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + 1'b1;
    end
  end
  // press = debounced falling edge; bit 0 is next, bit 1 is prev
  assign ev       = db_d1 & ~db;
  assign nx       = ev[0];
  assign pv       = ev[1];
  assign evt      = |ev;
  assign tgt_ev   = (nx == pv) ? target : nx ? target + 3'd1 : target - 3'd1;
  assign auto_hit = bus.auto_en && fcnt == FW'(AUTO_FRAMES - 1);
  always_comb begin
    state_n  = state;
    theme_n  = theme;
    target_n = tgt_ev;
    fcnt_n   = (evt || !bus.auto_en) ? '0 : fcnt;
    if (state == PENDING || evt) begin
      state_n = bus.frame_start ? IDLE : PENDING;
      theme_n = bus.frame_start ? tgt_ev : theme;
      fcnt_n  = bus.frame_start ? '0 : fcnt_n;
    end else if (bus.frame_start && bus.auto_en) begin
      fcnt_n   = auto_hit ? '0 : fcnt + 1'b1;
      theme_n  = auto_hit ? theme + 3'd1 : theme;
      target_n = theme_n;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      theme             <= RESET_THEME;
      target            <= RESET_THEME;
      fcnt              <= '0;
      bus.theme_changed <= 1'b0;
    end else begin
      state             <= state_n;
      theme             <= theme_n;
      target            <= target_n;
      fcnt              <= fcnt_n;
      bus.theme_changed <= theme_n != theme;
    end
  end
  assign bus.theme         = theme;
  assign bus.theme_pending = state == PENDING;
endmodule

// File: tb/tb_theme_sequencer.sv
// tb_theme_sequencer: directed scenarios plus random button/frame traffic against a history-based model
module tb_theme_sequencer;
  localparam int DB = 4;
  localparam int AF = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  theme_sequencer_if bus();
  theme_sequencer #(.DEBOUNCE_CYCLES(DB), .AUTO_FRAMES(AF), .RESET_THEME(3'd0)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_fail = 0;
  int m_theme, m_target, m_fc;
  bit m_pend, m_chg, auto_r;
  bit m_db [2];
  bit m_ev [2];
  logic [7:0] hist [2];
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask
  task automatic mdl_reset();
    m_theme = 0; m_target = 0; m_fc = 0; m_pend = 0; m_chg = 0;
    for (int i = 0; i < 2; i++) begin
      m_db[i] = 1'b1; m_ev[i] = 1'b0; hist[i] = '1;
    end
  endtask
  // One clock: drive inputs, advance, update the model from the rules, compare.
  task automatic step(input bit n, input bit p, input bit a, input bit f);
    bit nx, pv, was;
    int old;
    bus.btn_next_n = n; bus.btn_prev_n = p; bus.auto_en = a; bus.frame_start = f;
    @(posedge clk); #1;
    nx = m_ev[0]; pv = m_ev[1];
    was = m_pend || nx || pv;
    m_target = (m_target + int'(nx) - int'(pv) + 8) % 8;
    old = m_theme;
    if (f && was) begin
      m_theme = m_target; m_pend = 0;
    end else if (f && a && m_fc == AF - 1) begin
      m_theme = (m_theme + 1) % 8; m_target = m_theme;
    end else m_pend = was;
    if (nx || pv || !a) m_fc = 0;
    else if (f) m_fc = (was || m_fc == AF - 1) ? 0 : m_fc + 1;
    m_chg = m_theme != old;
    hist[0] = {hist[0][6:0], n};
    hist[1] = {hist[1][6:0], p};
    for (int i = 0; i < 2; i++) begin
      m_ev[i] = 1'b0;
      if (hist[i][DB+1:2] == {DB{~m_db[i]}}) begin
        m_ev[i] = m_db[i];
        m_db[i] = ~m_db[i];
      end
    end
    chk("theme", bus.theme, m_theme);
    chk("pending", bus.theme_pending, m_pend);
    chk("changed", bus.theme_changed, m_chg);
  endtask
  task automatic idle(input int k);
    repeat (k) step(1, 1, auto_r, 0);
  endtask
  task automatic press(input bit n, input bit p);
    repeat (8) step(n, p, auto_r, 0);
    idle(8);
  endtask
  task automatic frame();
    step(1, 1, auto_r, 1);
    step(1, 1, auto_r, 0);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    bus.btn_next_n = 1; bus.btn_prev_n = 1; bus.auto_en = 0; bus.frame_start = 0;
    mdl_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask
  initial begin
    bit n, p;
    auto_r = 0;
    bus.btn_next_n = 1; bus.btn_prev_n = 1; bus.auto_en = 0; bus.frame_start = 0;
    mdl_reset();
    @(posedge clk); #1;
    chk("rst_theme", bus.theme, 0);
    chk("rst_pending", bus.theme_pending, 0);
    chk("rst_changed", bus.theme_changed, 0);
    rst_n = 1'b1;
    repeat (3) step(0, 1, 0, 0);
    idle(10);
    step(1, 1, 0, 1);
    chk("glitch_theme", bus.theme, 0);
    chk("glitch_pending", bus.theme_pending, 0);
    chk("glitch_changed", bus.theme_changed, 0);
    repeat (10) step(0, 1, 0, 0);
    chk("hold_pending", bus.theme_pending, 1);
    idle(8);
    step(1, 1, 0, 1);
    chk("hold_theme", bus.theme, 1);
    chk("hold_changed", bus.theme_changed, 1);
    step(1, 1, 0, 0);
    chk("hold_changed_once", bus.theme_changed, 0);
    do_reset();
    press(1, 0);
    frame();
    chk("wrap_prev", bus.theme, 7);
    press(0, 1);
    press(0, 1);
    frame();
    chk("wrap_next2", bus.theme, 1);
    press(0, 0);
    chk("both_pending", bus.theme_pending, 1);
    step(1, 1, 0, 1);
    chk("both_theme", bus.theme, 1);
    chk("both_changed", bus.theme_changed, 0);
    do_reset();
    auto_r = 1;
    for (int k = 1; k <= 6; k++) begin
      frame();
      if (k == 3) chk("auto_3", bus.theme, 1);
      if (k == 6) chk("auto_6", bus.theme, 2);
    end
    frame();
    frame();
    press(0, 1);
    frame();
    chk("auto_manual", bus.theme, 3);
    frame();
    frame();
    chk("auto_restart_hold", bus.theme, 3);
    frame();
    chk("auto_restart_step", bus.theme, 4);
    auto_r = 0;
    repeat (10) step(0, 1, 0, 0);
    chk("rstmid_pending", bus.theme_pending, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_theme_async", bus.theme, 0);
    chk("rstmid_pending_async", bus.theme_pending, 0);
    bus.btn_next_n = 1;
    mdl_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(8);
    step(1, 1, 0, 1);
    chk("rstmid_theme", bus.theme, 0);
    chk("rstmid_pending_after", bus.theme_pending, 0);
    chk("rstmid_changed", bus.theme_changed, 0);
    n = 1; p = 1;
    repeat (4000) begin
      if ($urandom_range(0, 9) == 0) n = ~n;
      if ($urandom_range(0, 9) == 0) p = ~p;
      if ($urandom_range(0, 199) == 0) auto_r = ~auto_r;
      step(n, p, auto_r, $urandom_range(0, 7) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
